// File: rtl/jk_pair_sequencer_pkg.sv
// jk_seq_pkg: op encodings, FSM state type, command record and the
// shadow-state helper shared by jk_pair_sequencer and its testbench.
package jk_seq_pkg;

    // JK command encoding: J = op[1], K = op[0]
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Widest repeat count the command record can carry (CNT_W must not exceed it)
    localparam int CMD_CNT_W = 16;

    // Gap counter width, enough for GAP_CYC up to 15
    localparam int GAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP,
        ST_FIN
    } seq_state_t;

    // Latched command; cnt holds the pulses still to issue after the current one
    typedef struct packed {
        logic                 sel;
        logic [1:0]           op;
        logic [CMD_CNT_W-1:0] cnt;
    } cmd_t;

    // Flop state after one falling clock edge with J/K taken from op
    function automatic logic shadow_next(input logic q, input logic [1:0] op);
        case (op)
            OP_RESET:  return 1'b0;
            OP_SET:    return 1'b1;
            OP_TOGGLE: return ~q;
            default:   return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_pair_sequencer_if.sv
// jk_pair_sequencer_if: one requester command channel (valid/ready plus
// target flop, op and repeat count). master = requester, slave = sequencer.
interface jk_pair_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             Valid;
    logic             Ready;
    logic             Sel;
    logic [1:0]       Op;
    logic [CNT_W-1:0] Cnt;

    modport master (
        output Valid,
        output Sel,
        output Op,
        output Cnt,
        input  Ready
    );

    modport slave (
        input  Valid,
        input  Sel,
        input  Op,
        input  Cnt,
        output Ready
    );
endinterface

// File: rtl/jk_pair_sequencer_arb.sv
// jk_rr_arbiter: two-way round-robin grant with single-cycle ready strobes.
// grant records the most recent owner (0=A, 1=B); reset favours A.
module jk_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid_a,
    input  logic valid_b,
    output logic ready_a,
    output logic ready_b,
    output logic grant
);

    // Pick the lone requester, or the one that did not win last time
    always_comb begin
        ready_a = 1'b0;
        ready_b = 1'b0;
        if (en) begin
            ready_a = valid_a && (!valid_b || grant);
            ready_b = valid_b && (!valid_a || !grant);
        end
    end

    // Remember the owner of the accepted command
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= 1'b1;
        end else if (ready_a) begin
            grant <= 1'b0;
        end else if (ready_b) begin
            grant <= 1'b1;
        end
    end

endmodule

// File: rtl/jk_pair_sequencer.sv
// jk_pair_sequencer: shares an HC112-style dual JK flop between two
// requesters. Arbitrates, drives J/K, generates flop clock pulses, holds
// preset/clear and keeps a shadow copy of both flop states.
// Optional macro JKSEQ_CHECK_EN: compare returned Q against the shadow
// state after every clock pulse and raise a sticky Err on mismatch.
module jk_pair_sequencer
    import jk_seq_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    jk_pair_sequencer_if.slave        ReqA,
    jk_pair_sequencer_if.slave        ReqB,
    output logic                      J1,
    output logic                      K1,
    output logic                      J2,
    output logic                      K2,
    output logic                      Clk1,
    output logic                      Clk2,
    output logic                      S1,
    output logic                      S2,
    output logic                      R1,
    output logic                      R2,
    input  logic                      Q1,
    input  logic                      Q2,
    output logic [1:0]                ExpQ,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Grant,
    output logic                      Err
);

    seq_state_t       state, state_nxt;
    cmd_t             cmd_q, cmd_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic [1:0]       exp_nxt;
    logic             clr_d;
    logic             arb_en;
    logic             ready_a, ready_b;
    logic             run_nxt;
    logic             j1_nxt, k1_nxt, j2_nxt, k2_nxt, clk1_nxt, clk2_nxt;

    // Clear is held for the reset cycle and one more so the flops match ExpQ=00
    always_ff @(posedge Clk) begin
        clr_d <= Rst;
    end

    assign R1 = ~(Rst | clr_d);
    assign R2 = ~(Rst | clr_d);
    assign S1 = 1'b1;
    assign S2 = 1'b1;

    assign arb_en = (state == ST_IDLE) && !Rst && !clr_d;

    jk_rr_arbiter u_arb (
        .clk     (Clk),
        .rst     (Rst),
        .en      (arb_en),
        .valid_a (ReqA.Valid),
        .valid_b (ReqB.Valid),
        .ready_a (ready_a),
        .ready_b (ready_b),
        .grant   (Grant)
    );

    assign ReqA.Ready = ready_a;
    assign ReqB.Ready = ready_b;

    assign Busy = (state == ST_SETUP) || (state == ST_PULSE) ||
                  (state == ST_HOLD)  || (state == ST_GAP);
    assign Done = (state == ST_FIN);

    // Next-state, command bookkeeping, shadow update and next pin values.
    // Pins are computed from the next state and registered so the flop
    // clocks leave the block glitch-free.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        gap_nxt   = gap_q;
        exp_nxt   = ExpQ;
        case (state)
            ST_IDLE: begin
                if (ready_a) begin
                    cmd_nxt.sel = ReqA.Sel;
                    cmd_nxt.op  = ReqA.Op;
                    cmd_nxt.cnt = CMD_CNT_W'(ReqA.Cnt[CNT_W-1:0]);
                    state_nxt   = ST_SETUP;
                end else if (ready_b) begin
                    cmd_nxt.sel = ReqB.Sel;
                    cmd_nxt.op  = ReqB.Op;
                    cmd_nxt.cnt = CMD_CNT_W'(ReqB.Cnt[CNT_W-1:0]);
                    state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_PULSE;
            ST_PULSE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                exp_nxt[cmd_q.sel] = shadow_next(ExpQ[cmd_q.sel], cmd_q.op);
                if (cmd_q.cnt == '0) begin
                    state_nxt = ST_FIN;
                end else begin
                    cmd_nxt.cnt = cmd_q.cnt - CMD_CNT_W'(1);
                    gap_nxt     = GAP_W'(GAP_CYC - 1);
                    state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_nxt = ST_PULSE;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        run_nxt  = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE) ||
                   (state_nxt == ST_HOLD)  || (state_nxt == ST_GAP);
        j1_nxt   = run_nxt && !cmd_nxt.sel && cmd_nxt.op[1];
        k1_nxt   = run_nxt && !cmd_nxt.sel && cmd_nxt.op[0];
        j2_nxt   = run_nxt &&  cmd_nxt.sel && cmd_nxt.op[1];
        k2_nxt   = run_nxt &&  cmd_nxt.sel && cmd_nxt.op[0];
        clk1_nxt = (state_nxt == ST_PULSE) && !cmd_nxt.sel;
        clk2_nxt = (state_nxt == ST_PULSE) &&  cmd_nxt.sel;
    end

    // State, command, shadow and registered flop pins; reset aborts at once
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            cmd_q <= '0;
            gap_q <= '0;
            ExpQ  <= '0;
            J1    <= 1'b0;
            K1    <= 1'b0;
            J2    <= 1'b0;
            K2    <= 1'b0;
            Clk1  <= 1'b0;
            Clk2  <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            gap_q <= gap_nxt;
            ExpQ  <= exp_nxt;
            J1    <= j1_nxt;
            K1    <= k1_nxt;
            J2    <= j2_nxt;
            K2    <= k2_nxt;
            Clk1  <= clk1_nxt;
            Clk2  <= clk2_nxt;
        end
    end

`ifdef JKSEQ_CHECK_EN
    logic chk_pend;
    logic q_sel;

    assign q_sel = cmd_q.sel ? Q2 : Q1;

    // One cycle after each falling flop edge, compare the pin with the shadow
    always_ff @(posedge Clk) begin
        if (Rst) begin
            chk_pend <= 1'b0;
            Err      <= 1'b0;
        end else begin
            chk_pend <= (state == ST_HOLD);
            if (chk_pend && (q_sel != ExpQ[cmd_q.sel])) begin
                Err <= 1'b1;
            end
        end
    end
`else
    logic unused_q;

    assign unused_q = Q1 ^ Q2;
    assign Err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_pair_sequencer.sv
// tb_jk_pair_sequencer: directed table-driven bench for jk_pair_sequencer
// with a behavioural HC112 flop pair closing the Q loop.
`timescale 1ns/1ps
module tb_jk_pair_sequencer;
    import jk_seq_pkg::*;

    localparam int CNT_W   = 4;
    localparam int GAP_CYC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_pair_sequencer_if #(.CNT_W(CNT_W)) req_a_if ();
    jk_pair_sequencer_if #(.CNT_W(CNT_W)) req_b_if ();

    logic       j1, k1, j2, k2, clk1, clk2, s1, s2, r1, r2, q1, q2;
    logic [1:0] exp_q;
    logic       busy, done, grant, err;

    jk_pair_sequencer #(.CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .ReqA  (req_a_if),
        .ReqB  (req_b_if),
        .J1    (j1),
        .K1    (k1),
        .J2    (j2),
        .K2    (k2),
        .Clk1  (clk1),
        .Clk2  (clk2),
        .S1    (s1),
        .S2    (s2),
        .R1    (r1),
        .R2    (r2),
        .Q1    (q1),
        .Q2    (q2),
        .ExpQ  (exp_q),
        .Busy  (busy),
        .Done  (done),
        .Grant (grant),
        .Err   (err)
    );

    // Behavioural negative-edge JK flop pair with async active-low clear
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    logic m_q1 = 1'b0;
    logic m_q2 = 1'b0;
    logic force_en = 1'b0;
    logic force_q1 = 1'b0;

    always @(negedge clk1 or negedge r1) begin
        if (!r1) m_q1 <= 1'b0;
        else     m_q1 <= jk_next(m_q1, j1, k1);
    end
    always @(negedge clk2 or negedge r2) begin
        if (!r2) m_q2 <= 1'b0;
        else     m_q2 <= jk_next(m_q2, j2, k2);
    end

    assign q1 = force_en ? force_q1 : m_q1;
    assign q2 = m_q2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reset pulse: checks outputs during reset, the extra clear cycle, release
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_r", int'({r1, r2}), 0);
        check("rst_s", int'({s1, s2}), 3);
        check("rst_clk", int'({clk1, clk2}), 0);
        check("rst_jk", int'({j1, k1, j2, k2}), 0);
        check("rst_expq", int'(exp_q), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        check("rst_grant", int'(grant), 1);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'({req_a_if.Ready, req_b_if.Ready}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_clr_extra", int'({r1, r2}), 0);
        check("rst_ready_extra", int'({req_a_if.Ready, req_b_if.Ready}), 0);
        @(negedge clk);
        check("rst_clr_release", int'({r1, r2}), 3);
    endtask

    task automatic drive(input bit req, input bit valid, input bit sel,
                         input logic [1:0] op, input int cnt);
        if (req) begin
            req_b_if.Valid = valid; req_b_if.Sel = sel;
            req_b_if.Op = op;       req_b_if.Cnt = CNT_W'(cnt);
        end else begin
            req_a_if.Valid = valid; req_a_if.Sel = sel;
            req_a_if.Op = op;       req_a_if.Cnt = CNT_W'(cnt);
        end
    endtask

    // Present a command from one requester, wait (bounded) for its Ready,
    // then withdraw it; returns at the negedge of the SETUP cycle
    task automatic issue(input bit req, input bit sel, input logic [1:0] op,
                         input int cnt, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        drive(req, 1'b1, sel, op, cnt);
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req ? req_b_if.Ready : req_a_if.Ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        @(negedge clk);
        drive(req, 1'b0, sel, op, cnt);
    endtask

    // Run one command to completion and check timing, pulses and end state
    task automatic run_cmd(input string tag, input bit req, input bit sel,
                           input logic [1:0] op, input int cnt,
                           input int want_q, input int want_done);
        bit ok;
        int waited, done_at, pulses, other, first_p, last_p, jk_bad, busy_setup;
        issue(req, sel, op, cnt, ok, waited);
        check({tag, "_ready"}, int'(ok), 1);
        check({tag, "_ready_wait"}, waited, 0);
        done_at = -1; pulses = 0; other = 0; first_p = -1; last_p = -1; jk_bad = 0;
        busy_setup = int'(busy);
        for (int c = 1; c <= 150; c++) begin
            if (sel ? clk2 : clk1) begin
                pulses++;
                if (first_p < 0) first_p = c;
                last_p = c;
            end
            if (sel ? clk1 : clk2) other++;
            if (sel ? (j1 | k1) : (j2 | k2)) jk_bad++;
            if (done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_busy_setup"}, busy_setup, 1);
        check({tag, "_done_cycle"}, done_at, want_done);
        check({tag, "_pulses"}, pulses, cnt + 1);
        check({tag, "_spacing"}, last_p - first_p, (2 + GAP_CYC) * cnt);
        check({tag, "_other_clk"}, other, 0);
        check({tag, "_other_jk"}, jk_bad, 0);
        check({tag, "_fin_jk_busy"}, int'({j1, k1, j2, k2, busy}), 0);
        check({tag, "_expq"}, int'(exp_q), want_q);
        check({tag, "_flops"}, int'({m_q2, m_q1}), want_q);
        check({tag, "_grant"}, int'(grant), int'(req));
        @(negedge clk);
        check({tag, "_done_1cyc"}, int'(done), 0);
    endtask

    typedef struct {
        string      tag;
        bit         req;
        bit         sel;
        logic [1:0] op;
        int         cnt;
        int         want_q;
        int         want_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int waited, ng, both, rdy_busy, pulses, done_seen;
        int gnt[3];
        int gcyc[3];

        // accept cycle 0; done = 4 + 3*cnt with GAP_CYC=1; ExpQ = {flop2, flop1}
        vecs[0] = '{"v0_a_f1_set",     1'b0, 1'b0, OP_SET,    0,  1, 4};
        vecs[1] = '{"v1_b_f2_tog3",    1'b1, 1'b1, OP_TOGGLE, 2,  3, 10};
        vecs[2] = '{"v2_a_f2_rst2",    1'b0, 1'b1, OP_RESET,  1,  1, 7};
        vecs[3] = '{"v3_b_f1_hold",    1'b1, 1'b0, OP_HOLD,   0,  1, 4};
        vecs[4] = '{"v4_a_f1_tog16",   1'b0, 1'b0, OP_TOGGLE, 15, 1, 49};
        vecs[5] = '{"v5_b_f2_set4",    1'b1, 1'b1, OP_SET,    3,  3, 13};
        vecs[6] = '{"v6_a_f1_rst",     1'b0, 1'b0, OP_RESET,  0,  2, 4};

        // Both requesters valid straight out of reset: A, B, A
        drive(1'b0, 1'b1, 1'b0, OP_SET, 0);
        drive(1'b1, 1'b1, 1'b1, OP_SET, 0);
        do_reset();
        gnt = '{-1, -1, -1};
        gcyc = '{-1, -1, -1};
        ng = 0; both = 0; rdy_busy = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            #1;
            if (req_a_if.Ready && req_b_if.Ready) both++;
            if ((req_a_if.Ready || req_b_if.Ready) && busy) rdy_busy++;
            if (req_a_if.Ready || req_b_if.Ready) begin
                gnt[ng] = int'(req_b_if.Ready);
                gcyc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, OP_HOLD, 0);
        drive(1'b1, 1'b0, 1'b0, OP_HOLD, 0);
        check("arb_grants", ng, 3);
        check("arb_first_a", gnt[0], 0);
        check("arb_second_b", gnt[1], 1);
        check("arb_third_a", gnt[2], 0);
        check("arb_both_ready", both, 0);
        check("arb_ready_busy", rdy_busy, 0);
        check("arb_regrant_gap", gcyc[1] - gcyc[0], 5);
        check("arb_first_at_release", gcyc[0], 0);
        repeat (8) @(negedge clk);
        check("arb_expq", int'(exp_q), 3);
        check("arb_last_grant", int'(grant), 0);

        // Single-requester command table
        do_reset();
        foreach (vecs[i]) begin
            run_cmd(vecs[i].tag, vecs[i].req, vecs[i].sel, vecs[i].op,
                    vecs[i].cnt, vecs[i].want_q, vecs[i].want_done);
        end
        check("table_err", int'(err), 0);

        // Reset during the second pulse of a Cnt=3 command
        do_reset();
        issue(1'b0, 1'b0, OP_TOGGLE, 3, ok, waited);
        check("mid_ready", int'(ok), 1);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (clk1) pulses++;
            if (pulses == 2) break;
            @(negedge clk);
        end
        check("mid_reach_pulse2", pulses, 2);
        check("mid_expq_before", int'(exp_q), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_clk", int'({clk1, clk2}), 0);
        check("mid_expq", int'(exp_q), 0);
        check("mid_r", int'({r1, r2}), 0);
        check("mid_done_busy", int'({done, busy}), 0);
        rst = 1'b0;
        #1;
        check("mid_r_extra", int'({r1, r2}), 0);
        done_seen = 0;
        @(negedge clk);
        check("mid_r_release", int'({r1, r2}), 3);
        for (int c = 0; c < 8; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("mid_no_done", done_seen, 0);
        check("mid_flops", int'({m_q2, m_q1}), 0);

        // Q1 held opposite to the shadow after a SET
        force_en = 1'b1;
        force_q1 = 1'b0;
        run_cmd("chk_set", 1'b0, 1'b0, OP_SET, 0, 1, 4);
        force_en = 1'b0;
        run_cmd("chk_after", 1'b1, 1'b1, OP_SET, 0, 3, 4);
`ifdef JKSEQ_CHECK_EN
        check("chk_err_sticky", int'(err), 1);
        repeat (3) @(negedge clk);
        check("chk_err_still", int'(err), 1);
`else
        check("chk_err_tied", int'(err), 0);
`endif
        do_reset();
        check("chk_err_cleared", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jk_pair_sequencer.md
Name: jk_pair_sequencer

Overview:
Synchronous controller that shares one dual negative-edge JK flip-flop pair (HC112-style) between two command requesters. It performs round-robin arbitration, then sequences the selected flop. For each command it drives J/K, generates clock pulses and holds the inactive-low preset/clear lines. It keeps a shadow copy of both flop states so the expected Q is known without reading the pins.

Parameters:
CNT_W, 4, width of the repeat-count field; a command issues req_cnt+1 clock pulses.
GAP_CYC, 1, idle cycles between consecutive pulses of one command; legal range 1..15.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst  in  1  reset, synchronous, active-high.
ReqA_Valid  in  1  requester A has a command.
ReqA_Ready  out  1  A command accepted this cycle.
ReqA_Sel  in  1  target flop: 0=flop1, 1=flop2.
ReqA_Op  in  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
ReqA_Cnt  in  CNT_W  repeat count.
ReqB_Valid / ReqB_Ready / ReqB_Sel / ReqB_Op / ReqB_Cnt: same as the A ports, for requester B.
J1, K1, J2, K2  out  1 each  JK inputs to the flop pair.
Clk1, Clk2  out  1 each  generated flop clocks; the falling edge clocks the flop.
S1, S2  out  1 each  active-low preset; always 1.
R1, R2  out  1 each  active-low clear.
Q1, Q2  in  1 each  returned flop outputs; used only with the optional feature.
ExpQ  out  2  shadow state {flop2, flop1}.
Busy  out  1  a command is in progress.
Done  out  1  one-cycle pulse when a command completes.
Grant  out  1  owner of the current or last command: 0=A, 1=B.
Err  out  1  sticky mismatch flag.

Behaviour:
- Reset (Rst high at a rising edge): state returns to IDLE, ExpQ=00, all J/K=0, Clk1=Clk2=0, Ready=0, Busy=0, Done=0, Grant=1 (so A wins first), Err=0.
  - R1=R2=0 while Rst is high and for one cycle after it deasserts, then 1. This clear forces ExpQ=00 to be true on the flops.
  - S1=S2=1 always.
- Reset mid-command aborts the command immediately. No Done is issued and the clock output returns to 0.
- FSM states: IDLE, SETUP, PULSE, HOLD, GAP, FIN.
- IDLE:
  - Waits for R1/R2 to be released.
  - One valid requester: grant it.
  - Both valid: grant the requester that is not the current Grant (round-robin).
  - The granted Ready is 1 for exactly that cycle and the command fields are latched.
  - Next state SETUP, Busy=1.
- SETUP (1 cycle): drive J/K of the selected flop from Op (J=Op[1], K=Op[0]). The unselected flop keeps J=K=0.
- PULSE (1 cycle): selected Clk=1.
- HOLD (1 cycle): Clk=0, which is the flop's falling edge. J/K stay stable.
  - Update the shadow bit: HOLD keeps, RESET→0, SET→1, TOGGLE→invert.
  - Decrement the remaining count.
- Counted pulses remaining: go to GAP for GAP_CYC cycles, then PULSE.
- Count exhausted: go to FIN.
- FIN (1 cycle): J/K=0, Done=1, Busy=0, then IDLE. A new grant can occur on the cycle after FIN.
- Minimum command length: 4 cycles from accept to Done for Cnt=0. Each additional pulse adds 2+GAP_CYC cycles.
- Count uses CNT_W-bit arithmetic. Cnt at its maximum value (2^CNT_W−1) gives 2^CNT_W pulses; no overflow.
- A requester may drop Valid before Ready with no effect. Commands are never queued; Ready is 0 whenever Busy=1.

Optional Feature:
JKSEQ_CHECK_EN:
- Defined: on the cycle after each HOLD, compare Q of the selected flop with its ExpQ bit. Any mismatch sets Err, which stays set until Rst.
- Undefined: Err is tied to 0 and Q1/Q2 are unused.

Decomposition:
- Package jk_seq_pkg holds the op encoding constants (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE), the FSM state enum and the command struct {sel, op, cnt}.
- One sub-module, jk_rr_arbiter: 2-way round-robin grant plus Ready generation.

Test Plan:
- Reset, then A: Sel=0, Op=SET, Cnt=0 → Ready at cycle 0; one Clk1 pulse; Done at cycle 4; ExpQ=01; Clk2 stays 0.
- B: Sel=1, Op=TOGGLE, Cnt=2, GAP_CYC=1 → three Clk2 pulses, 3 cycles apart; ExpQ[1] ends at 1; Done at cycle 10.
- A and B both valid in IDLE right after reset → A granted first, then B, then A again while both stay valid.
- Rst asserted during the second pulse of a Cnt=3 command → no Done; R1=R2=0 for the reset cycle plus one more; ExpQ=00; Clk outputs 0.
- Cnt=15 (CNT_W=4), Op=TOGGLE → exactly 16 pulses; ExpQ bit unchanged.
- With JKSEQ_CHECK_EN defined, force Q1 opposite to ExpQ after a SET → Err=1 and it remains 1 until Rst.
